cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Arbitrates the single common data bus (CDB) between out_of_order's functional units (ALU, MUL, DIV, LSU).
//  Grants one completed result per cycle, then broadcasts it registered to the ROB and reservation stations.
//  Losing FUs hold their result until granted. Forced grants prevent starvation of any FU.
//  A flush discards the in-cycle winner and clears the fairness state.
// PARAMETERS
//  NUM_FU       4   number of requesting functional units
//  TAG_W        5   ROB tag width (ROB depth = 2**TAG_W)
//  DATA_W       32  result width
//  STARVE_LIMIT 7   consecutive denied cycles before a forced grant (>=1)
// PORTS
//  clk        in   1               clock, rising edge
//  reset      in   1               synchronous, active-high
//  fu_valid   in   NUM_FU          FU i has a completed result
//  fu_tag     in   NUM_FU x TAG_W  ROB tag of FU i result
//  fu_data    in   NUM_FU x DATA_W result value of FU i
//  fu_ready   out  NUM_FU          one-hot grant; combinational, same cycle as request
//  rob_head   in   TAG_W           current ROB head tag (oldest in flight)
//  flush      in   1               mispredict recovery; kill everything this cycle
//  cdb_valid  out  1               broadcast valid (registered)
//  cdb_tag    out  TAG_W           broadcast ROB tag
//  cdb_data   out  DATA_W          broadcast value
//  cdb_src    out  $clog2(NUM_FU)  index of the granted FU
// BEHAVIOUR
//  Reset: cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, rr_ptr=0, all starve_cnt=0. fu_ready=0 while reset is high.
//  Handshake: a transfer occurs when fu_valid[i] && fu_ready[i] in the same cycle.
//   FU holds valid, tag and data stable until ready. fu_ready never asserts without fu_valid.
//   At most one fu_ready bit is high per cycle.
//  Latency: granted result appears on cdb_* on the next rising edge, for exactly 1 cycle.
//   cdb_valid=0 in every cycle with no grant.
//  Selection priority per cycle, first match wins:
//   1. flush=1: no grant. fu_ready=0. Next cycle cdb_valid=0. All starve_cnt cleared. rr_ptr unchanged.
//   2. Forced grant: any valid FU with starve_cnt==STARVE_LIMIT. Lowest index among such FUs wins.
//   3. Normal pick: round-robin starting at rr_ptr, or age order (see CONFIGURATION).
//  rr_ptr: after any grant to FU g, rr_ptr <= (g+1) mod NUM_FU. Unchanged when there is no grant.
//  starve_cnt[i]:
//   - increments when fu_valid[i] is high and FU i is not granted; saturates at STARVE_LIMIT.
//   - clears on grant to FU i, when fu_valid[i]=0, or on flush.
//  No requests: fu_ready=0, and cdb_valid=0 next cycle.
//  Reset asserted mid-transfer: the pending broadcast is dropped; outputs take reset values next edge.
//  Tag width: all tag arithmetic is modulo 2**TAG_W (wrap-around safe).
// CONFIGURATION
//  Macro CDB_AGE_PRIORITY_EN.
//  Defined: the normal pick is oldest-first.
//   - age_i = (fu_tag[i] - rob_head) mod 2**TAG_W; smallest age wins.
//   - equal age resolves to the lowest index.
//   - rr_ptr is still maintained but not used for selection.
//  Undefined: the normal pick is pure round-robin from rr_ptr; rob_head is unused (lint waiver).
//  Starvation forcing and flush behaviour are identical in both builds.
// STRUCTURE
//  Package cdb_pkg:
//   - typedef cdb_pkt_t {valid, tag, data, src}
//   - localparams FU_ALU=0, FU_MUL=1, FU_DIV=2, FU_LSU=3
//   - function rob_age(tag, head)
//  Sub-module cdb_rr_picker: rotating-priority one-hot picker (req, ptr -> gnt). Purely combinational.
//  Top level holds rr_ptr, the starve counters, the output register and the priority mux.
// TESTING
//  1. Reset: reset=1 for 2 cycles with all fu_valid=1 -> fu_ready=0, cdb_valid=0, rr_ptr=0.
//  2. Round-robin (macro off): fu_valid=4'b1111 held for 4 cycles.
//     -> grants go to FU 0,1,2,3; cdb_src sequence 0,1,2,3, each 1 cycle after its grant.
//  3. Age order (macro on): rob_head=30; ALU tag=2, MUL tag=31.
//     -> MUL granted first (age 1 vs 4); cdb_tag=31, then cdb_tag=2.
//  4. Starvation (macro on, STARVE_LIMIT=7): rob_head=0; DIV held valid with tag=20.
//     ALU issues new tags 1,2,3,... every cycle.
//     -> DIV is denied 7 cycles, then force-granted on the 8th; DIV starve_cnt returns to 0.
//  5. Flush: FU1 valid tag=9 with flush=1 -> fu_ready=0, cdb_valid=0 next cycle, counters=0.
//     Flush low and FU1 still valid -> grant on the following cycle.
//  6. Back-to-back single FU: LSU valid for 3 consecutive results (tags 4,5,6).
//     -> granted every cycle; cdb_valid high 3 consecutive cycles with tags 4,5,6.

Source files
------------

// File: rtl/cdb_pkg.sv
// Shared types and helpers for the common-data-bus arbiter.
// Build option: CDB_AGE_PRIORITY_EN selects oldest-first normal picking.
package cdb_pkg;

  localparam int FU_ALU = 0;
  localparam int FU_MUL = 1;
  localparam int FU_DIV = 2;
  localparam int FU_LSU = 3;

  localparam int CDB_TAG_W  = 5;
  localparam int CDB_DATA_W = 32;
  localparam int CDB_SRC_W  = 2;

  typedef struct packed {
    logic                  valid;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
    logic [CDB_SRC_W-1:0]  src;
  } cdb_pkt_t;

  // Distance of a tag from the ROB head, modulo the ROB depth.
  function automatic logic [31:0] rob_age(input logic [31:0] tag,
                                          input logic [31:0] head,
                                          input int unsigned tag_w);
    logic [31:0] mask;
    mask = (32'd1 << tag_w) - 32'd1;
    return (tag - head) & mask;
  endfunction

endpackage

// File: rtl/cdb_rr_picker.sv
// Rotating-priority one-hot picker: first requester at or after ptr wins.
module cdb_rr_picker #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  always_comb begin
    logic found;
    int   idx;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one grant per cycle (forced anti-starvation, then RR or age),
// registered broadcast. Build option: CDB_AGE_PRIORITY_EN (oldest-first pick).
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_FU       = 4,
  parameter int TAG_W        = 5,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 7,
  localparam int SRC_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_FU-1:0]              fu_valid,
  input  logic [NUM_FU-1:0][TAG_W-1:0]   fu_tag,
  input  logic [NUM_FU-1:0][DATA_W-1:0]  fu_data,
  output logic [NUM_FU-1:0]              fu_ready,
  input  logic [TAG_W-1:0]               rob_head,
  input  logic                           flush,
  output logic                           cdb_valid,
  output logic [TAG_W-1:0]               cdb_tag,
  output logic [DATA_W-1:0]              cdb_data,
  output logic [SRC_W-1:0]               cdb_src,
  output logic [SRC_W-1:0]               dbg_rr_ptr,
  output logic [NUM_FU-1:0][CNT_W-1:0]   dbg_starve_cnt
);

  // Handshake: FU i transfers when fu_valid[i] && fu_ready[i] in the same
  // cycle; an FU holds tag/data stable until then, fu_ready is one-hot or zero
  // and never asserts without fu_valid.

  logic [SRC_W-1:0]             rr_ptr;
  logic [NUM_FU-1:0][CNT_W-1:0] starve_cnt;
  logic [NUM_FU-1:0]            forced_mask;
  logic [NUM_FU-1:0]            normal_gnt;
  logic [NUM_FU-1:0]            gnt;
  logic [SRC_W-1:0]             gnt_idx;
  logic                         gnt_any;

  always_comb begin
    forced_mask = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      forced_mask[i] = fu_valid[i] && (starve_cnt[i] == CNT_W'(STARVE_LIMIT));
    end
  end

`ifdef CDB_AGE_PRIORITY_EN
  // Oldest-first; strict less-than keeps the lowest index on equal age.
  always_comb begin
    logic [31:0] best_age;
    logic [31:0] age;
    int          best_i;
    logic        found;
    best_age   = '1;
    age        = '0;
    best_i     = 0;
    found      = 1'b0;
    normal_gnt = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (fu_valid[i]) begin
        age = rob_age(32'(fu_tag[i]), 32'(rob_head), TAG_W);
        if (!found || age < best_age) begin
          best_age = age;
          best_i   = i;
          found    = 1'b1;
        end
      end
    end
    if (found) normal_gnt[best_i] = 1'b1;
  end
`else
  logic unused_rob_head;
  assign unused_rob_head = ^rob_head;

  cdb_rr_picker #(
    .N  (NUM_FU),
    .PW (SRC_W)
  ) u_picker (
    .req (fu_valid),
    .ptr (rr_ptr),
    .gnt (normal_gnt)
  );
`endif

  always_comb begin
    logic found;
    gnt   = '0;
    found = 1'b0;
    if (!reset && !flush) begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (!found && forced_mask[i]) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
      if (!found) gnt = normal_gnt;
    end
  end

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (gnt[i]) gnt_idx = SRC_W'(i);
    end
  end

  assign gnt_any  = |gnt;
  assign fu_ready = gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cdb_valid  <= 1'b0;
      cdb_tag    <= '0;
      cdb_data   <= '0;
      cdb_src    <= '0;
      rr_ptr     <= '0;
      starve_cnt <= '0;
    end else begin
      cdb_valid <= gnt_any;
      if (gnt_any) begin
        cdb_tag  <= fu_tag[gnt_idx];
        cdb_data <= fu_data[gnt_idx];
        cdb_src  <= gnt_idx;
        rr_ptr   <= (gnt_idx == SRC_W'(NUM_FU - 1)) ? '0 : gnt_idx + SRC_W'(1);
      end
      for (int i = 0; i < NUM_FU; i++) begin
        if (flush || !fu_valid[i] || gnt[i]) begin
          starve_cnt[i] <= '0;
        end else if (starve_cnt[i] != CNT_W'(STARVE_LIMIT)) begin
          starve_cnt[i] <= starve_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign dbg_rr_ptr     = rr_ptr;
  assign dbg_starve_cnt = starve_cnt;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus a randomized
// run against a rule-level reference model (both CDB_AGE_PRIORITY_EN builds).
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int N     = 4;
  localparam int LIMIT = 7;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      fu_valid;
  logic [3:0][4:0] fu_tag;
  logic [3:0][31:0] fu_data;
  logic [3:0]      fu_ready;
  logic [4:0]      rob_head;
  logic            flush;
  logic            cdb_valid;
  logic [4:0]      cdb_tag;
  logic [31:0]     cdb_data;
  logic [1:0]      cdb_src;
  logic [1:0]      dbg_rr_ptr;
  logic [3:0][2:0] dbg_starve_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state: round-robin pointer and per-FU denied-cycle counts.
  int m_rr;
  int m_sc[N];

  cdb_pkt_t exp_q[$];

  always #5 clk = ~clk;

  cdb_arbiter #(
    .NUM_FU(4), .TAG_W(5), .DATA_W(32), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset(reset), .fu_valid(fu_valid), .fu_tag(fu_tag),
    .fu_data(fu_data), .fu_ready(fu_ready), .rob_head(rob_head), .flush(flush),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_src(cdb_src), .dbg_rr_ptr(dbg_rr_ptr), .dbg_starve_cnt(dbg_starve_cnt)
  );

  function automatic int model_pick();
    int best;
    int ba;
    int a;
    if (reset || flush) return -1;
    for (int i = 0; i < N; i++) begin
      if (fu_valid[i] && m_sc[i] == LIMIT) return i;
    end
`ifdef CDB_AGE_PRIORITY_EN
    best = -1;
    ba   = 0;
    for (int i = 0; i < N; i++) begin
      if (fu_valid[i]) begin
        a = (int'(fu_tag[i]) - int'(rob_head) + 32) % 32;
        if (best < 0 || a < ba) begin
          best = i;
          ba   = a;
        end
      end
    end
    return best;
`else
    for (int k = 0; k < N; k++) begin
      if (fu_valid[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
`endif
  endfunction

  task automatic model_update(input int g);
    if (reset) begin
      m_rr = 0;
      for (int i = 0; i < N; i++) m_sc[i] = 0;
    end else if (flush) begin
      for (int i = 0; i < N; i++) m_sc[i] = 0;
    end else begin
      if (g >= 0) m_rr = (g + 1) % N;
      for (int i = 0; i < N; i++) begin
        if (!fu_valid[i] || i == g) m_sc[i] = 0;
        else if (m_sc[i] < LIMIT) m_sc[i] = m_sc[i] + 1;
      end
    end
  endtask

  // One clock: inputs are already driven. Returns the sampled grant, the
  // model's grant, and the broadcast seen after the edge with its expectation.
  task automatic tick(output logic [3:0] got_rdy, output logic [3:0] exp_rdy,
                      output cdb_pkt_t got, output cdb_pkt_t exp);
    int g;
    #1;
    g       = model_pick();
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0;
    got_rdy = fu_ready;
    if (g >= 0) exp = '{1'b1, fu_tag[g], fu_data[g], 2'(g)};
    else        exp = '{1'b0, 5'd0, 32'd0, 2'd0};
    exp_q.push_back(exp);
    model_update(g);
    @(posedge clk);
    #1;
    got = '{cdb_valid, cdb_tag, cdb_data, cdb_src};
    exp = exp_q.pop_front();
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] gr, er;
    cdb_pkt_t got, exp;
    reset    = 1'b1;
    fu_valid = 4'hF;
    for (int i = 0; i < N; i++) begin
      fu_tag[i]  = 5'(i + 1);
      fu_data[i] = $urandom;
    end
    repeat (2) begin
      tick(gr, er, got, exp);
      checks++;
      if (gr !== 4'b0) begin
        errors++; $display("FAIL reset_ready got=%b want=0000", gr);
      end
      checks++;
      if (got !== '{1'b0, 5'd0, 32'd0, 2'd0}) begin
        errors++; $display("FAIL reset_cdb got=%h want=0", got);
      end
      checks++;
      if (dbg_rr_ptr !== 2'd0 || dbg_starve_cnt !== '0) begin
        errors++; $display("FAIL reset_state rr=%0d sc=%h want 0/0", dbg_rr_ptr, dbg_starve_cnt);
      end
    end
    reset    = 1'b0;
    fu_valid = 4'h0;
  endtask

`ifndef CDB_AGE_PRIORITY_EN
  task automatic test_round_robin();
    logic [3:0] gr, er;
    cdb_pkt_t got, exp;
    fu_valid = 4'hF;
    for (int c = 0; c < N; c++) begin
      tick(gr, er, got, exp);
      checks++;
      if (gr !== er || er !== 4'(1 << c)) begin
        errors++; $display("FAIL rr_grant c=%0d got=%b want=%b", c, gr, 4'(1 << c));
      end
      checks++;
      if (got !== exp || got.src !== 2'(c)) begin
        errors++; $display("FAIL rr_cdb c=%0d got=%h want=%h", c, got, exp);
      end
      fu_tag[c]  = fu_tag[c] + 5'd8;
      fu_data[c] = $urandom;
    end
    fu_valid = 4'h0;
    tick(gr, er, got, exp);
  endtask
`else
  task automatic test_age();
    logic [3:0] gr, er;
    cdb_pkt_t got, exp;
    rob_head   = 5'd30;
    fu_valid   = 4'b0011;
    fu_tag[0]  = 5'd2;
    fu_tag[1]  = 5'd31;
    tick(gr, er, got, exp);
    checks++;
    if (gr !== 4'b0010 || got.tag !== 5'd31 || got.valid !== 1'b1) begin
      errors++; $display("FAIL age_first ready=%b tag=%0d want 0010/31", gr, got.tag);
    end
    fu_valid = 4'b0001;
    tick(gr, er, got, exp);
    checks++;
    if (gr !== 4'b0001 || got.tag !== 5'd2 || got.valid !== 1'b1) begin
      errors++; $display("FAIL age_second ready=%b tag=%0d want 0001/2", gr, got.tag);
    end
    fu_valid = 4'h0;
    tick(gr, er, got, exp);
  endtask

  task automatic test_starvation();
    logic [3:0] gr, er;
    cdb_pkt_t got, exp;
    rob_head       = 5'd0;
    fu_valid       = 4'b0101;
    fu_tag[FU_DIV] = 5'd20;
    for (int c = 1; c <= 8; c++) begin
      fu_tag[FU_ALU] = 5'(c);
      tick(gr, er, got, exp);
      checks++;
      if (gr !== ((c < 8) ? 4'b0001 : 4'b0100)) begin
        errors++; $display("FAIL starve_grant c=%0d got=%b", c, gr);
      end
      if (c == 7) begin
        checks++;
        if (dbg_starve_cnt[FU_DIV] !== 3'd7) begin
          errors++; $display("FAIL starve_cnt_sat got=%0d want=7", dbg_starve_cnt[FU_DIV]);
        end
      end
    end
    checks++;
    if (dbg_starve_cnt[FU_DIV] !== 3'd0 || got.tag !== 5'd20) begin
      errors++; $display("FAIL starve_clear cnt=%0d tag=%0d want 0/20", dbg_starve_cnt[FU_DIV], got.tag);
    end
    fu_valid = 4'h0;
    tick(gr, er, got, exp);
  endtask
`endif

  task automatic test_flush();
    logic [3:0] gr, er;
    cdb_pkt_t got, exp;
    fu_valid  = 4'b0111;
    fu_tag[0] = 5'd1; fu_tag[1] = 5'd9; fu_tag[2] = 5'd3;
    tick(gr, er, got, exp);
    fu_valid = 4'b0010;
    flush    = 1'b1;
    tick(gr, er, got, exp);
    checks++;
    if (gr !== 4'b0 || got.valid !== 1'b0) begin
      errors++; $display("FAIL flush_kill ready=%b cdb_valid=%b want 0000/0", gr, got.valid);
    end
    checks++;
    if (dbg_starve_cnt !== '0 || dbg_rr_ptr !== 2'(m_rr)) begin
      errors++; $display("FAIL flush_state sc=%h rr=%0d want 0/%0d", dbg_starve_cnt, dbg_rr_ptr, m_rr);
    end
    flush = 1'b0;
    tick(gr, er, got, exp);
    checks++;
    if (gr !== 4'b0010 || got.tag !== 5'd9 || got.valid !== 1'b1) begin
      errors++; $display("FAIL flush_resume ready=%b tag=%0d want 0010/9", gr, got.tag);
    end
    fu_valid = 4'h0;
    tick(gr, er, got, exp);
  endtask

  task automatic test_back_to_back();
    logic [3:0] gr, er;
    cdb_pkt_t got, exp;
    fu_valid = 4'b1000;
    for (int t = 4; t <= 6; t++) begin
      fu_tag[FU_LSU]  = 5'(t);
      fu_data[FU_LSU] = $urandom;
      tick(gr, er, got, exp);
      checks++;
      if (gr !== 4'b1000 || got.valid !== 1'b1 || got.tag !== 5'(t) || got !== exp) begin
        errors++; $display("FAIL b2b t=%0d ready=%b cdb=%h want=%h", t, gr, got, exp);
      end
    end
    fu_valid = 4'h0;
    tick(gr, er, got, exp);
    checks++;
    if (got.valid !== 1'b0) begin
      errors++; $display("FAIL b2b_idle cdb_valid=%b want=0", got.valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] gr, er;
    cdb_pkt_t got, exp;
    fu_valid = 4'b1010;
    reset    = 1'b1;
    tick(gr, er, got, exp);
    checks++;
    if (gr !== 4'b0 || got !== '{1'b0, 5'd0, 32'd0, 2'd0} || dbg_rr_ptr !== 2'd0) begin
      errors++; $display("FAIL reset_mid ready=%b cdb=%h rr=%0d want 0", gr, got, dbg_rr_ptr);
    end
    reset    = 1'b0;
    fu_valid = 4'h0;
  endtask

  task automatic test_random();
    logic [3:0] gr, er;
    cdb_pkt_t got, exp;
    int bad;
    for (int c = 0; c < 400; c++) begin
      flush = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) rob_head = 5'($urandom_range(0, 31));
      tick(gr, er, got, exp);
      checks++;
      if (gr !== er) begin
        errors++; $display("FAIL rand_ready c=%0d got=%b want=%b", c, gr, er);
      end
      checks++;
      if (exp.valid ? (got !== exp) : (got.valid !== 1'b0)) begin
        errors++; $display("FAIL rand_cdb c=%0d got=%h want=%h", c, got, exp);
      end
      bad = (dbg_rr_ptr !== 2'(m_rr)) ? 1 : 0;
      for (int i = 0; i < N; i++) if (dbg_starve_cnt[i] !== 3'(m_sc[i])) bad = 1;
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL rand_state c=%0d rr=%0d want=%0d sc=%h", c, dbg_rr_ptr, m_rr, dbg_starve_cnt);
      end
      // FUs hold until granted, then may present a fresh result.
      for (int i = 0; i < N; i++) begin
        if (!fu_valid[i] || er[i]) begin
          fu_valid[i] = ($urandom_range(0, 3) != 0);
          fu_tag[i]   = 5'($urandom_range(0, 31));
          fu_data[i]  = $urandom;
        end
      end
    end
    flush    = 1'b0;
    fu_valid = 4'h0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset    = 1'b1;
    flush    = 1'b0;
    fu_valid = 4'h0;
    fu_tag   = '0;
    fu_data  = '0;
    rob_head = 5'd0;
    m_rr     = 0;
    for (int i = 0; i < N; i++) m_sc[i] = 0;
    @(posedge clk);
    #2;
    test_reset();
`ifndef CDB_AGE_PRIORITY_EN
    test_round_robin();
`else
    test_age();
    test_starvation();
`endif
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
